crc_stream_engine: RTL and testbench

- Parametrised successor to the team's serial CRC-8 block.
- Computes any CRC of width CRC_W (polynomial, init, reflection and xorout all set by parameters) over DATA_W bits per clock.
- Framed input with last-word marker and partial-last-word support.
- Sits between the packet datapath and framing/checking logic: one CRC per frame, one-cycle result strobe.

---
 rtl/crc_stream_engine.sv | 140 ++++++++++++++
 tb/tb_crc_stream_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: framed, parametrised CRC engine processing DATA_W bits
// per clock with a one-cycle result strobe after each last word.
// Optional feature: define CRC_STREAM_CHECK_EN to add the RESIDUE parameter
// and the crc_ok output that flags frames whose raw CRC equals RESIDUE.
module crc_stream_engine #(
  parameter int          CRC_W   = 8,
  parameter logic [63:0] POLY    = 64'h07,
  parameter logic [63:0] INIT    = 64'h0,
  parameter logic [63:0] XOR_OUT = 64'h0,
  parameter int          DATA_W  = 8,
  parameter bit          REFIN   = 1'b0,
  parameter bit          REFOUT  = 1'b0,
  parameter int          NB_W    = $clog2(DATA_W) + 1
`ifdef CRC_STREAM_CHECK_EN
  ,
  parameter logic [63:0] RESIDUE = 64'h0
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_last,
  input  logic [NB_W-1:0]   din_nbits,
  input  logic              clr,
  output logic [CRC_W-1:0]  dout,
  output logic              dout_vld,
`ifdef CRC_STREAM_CHECK_EN
  output logic              crc_ok,
`endif
  output logic              busy
);

  localparam logic [CRC_W-1:0] POLY_T = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_T = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_T  = XOR_OUT[CRC_W-1:0];
`ifdef CRC_STREAM_CHECK_EN
  localparam logic [CRC_W-1:0] RESIDUE_T = RESIDUE[CRC_W-1:0];
`endif

  typedef enum logic {IDLE, ACC} state_t;

  state_t            state, state_nxt;
  logic [CRC_W-1:0]  crc_reg, crc_nxt, next_crc, result;
  logic [CRC_W-1:0]  acc, rev, rtmp;
  logic [DATA_W-1:0] word;
  logic              bit_in, fb, finish;
  int                nbits_eff;

  // Number of bits of this word that take part: all of them except on a
  // partial last word, where zero still means a full word.
  always_comb begin
    nbits_eff = DATA_W;
    if (din_last && din_nbits != '0 && int'(din_nbits) < DATA_W)
      nbits_eff = int'(din_nbits);
  end

  // Advance the register over the valid bits of the word in one step; the
  // word is shifted so the next bit in processing order is always at an end.
  always_comb begin
    word   = din;
    acc    = crc_reg;
    bit_in = 1'b0;
    fb     = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits_eff) begin
        bit_in = REFIN ? word[0] : word[DATA_W-1];
        fb     = acc[CRC_W-1] ^ bit_in;
        acc    = (acc << 1) ^ (fb ? POLY_T : '0);
      end
      word = REFIN ? (word >> 1) : (word << 1);
    end
    next_crc = acc;
  end

  // Final result: optional bit reversal followed by the output XOR mask.
  always_comb begin
    rev  = '0;
    rtmp = next_crc;
    for (int j = 0; j < CRC_W; j++) begin
      rev    = rev << 1;
      rev[0] = rtmp[0];
      rtmp   = rtmp >> 1;
    end
    result = (REFOUT ? rev : next_crc) ^ XOR_T;
  end

  // Next state, next register value and frame-complete decision; clr wins
  // over any word presented in the same cycle.
  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_reg;
    finish    = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      crc_nxt   = INIT_T;
    end else if (din_vld) begin
      if (din_last) begin
        state_nxt = IDLE;
        crc_nxt   = INIT_T;
        finish    = 1'b1;
      end else begin
        state_nxt = ACC;
        crc_nxt   = next_crc;
      end
    end
  end

  // State and running CRC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      crc_reg <= INIT_T;
    end else begin
      state   <= state_nxt;
      crc_reg <= crc_nxt;
    end
  end

  // Result register: loaded only when a frame completes, strobe for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
      crc_ok   <= 1'b0;
`endif
    end else begin
      dout_vld <= finish;
      if (finish)
        dout <= result;
`ifdef CRC_STREAM_CHECK_EN
      crc_ok   <= finish && (next_crc == RESIDUE_T);
`endif
    end
  end

  assign busy = (state == ACC);

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: scoreboard bench for crc_stream_engine. Three byte-wide
// engines (CRC-8, CRC-16/CCITT-FALSE, reflected CRC-32) share one input bus;
// a bit-serial CRC-8 engine has its own bus. Expected results come from a
// frame-level model that flattens each frame into a bit list.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_vld = 1'b0;
  logic        din_last = 1'b0;
  logic [3:0]  din_nbits = '0;
  logic        clr = 1'b0;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [31:0] d32;
  logic        v8, v16, v32, b8, b16, b32;

  logic [0:0]  b_din = '0;
  logic        b_vld = 1'b0;
  logic        b_last = 1'b0;
  logic [0:0]  b_nbits = '0;
  logic        b_clr = 1'b0;
  logic [7:0]  bd;
  logic        bv, bb;

`ifdef CRC_STREAM_CHECK_EN
  logic ok8, ok16, ok32, okb;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  bit          msb_bits[$];
  bit          lsb_bits[$];
  bit          ser_bits[$];
  logic [31:0] sq[4][$];
  logic [31:0] hold[4];
  bit          in_frame = 1'b0;
  bit          b_in_frame = 1'b0;

  always #5 clk = ~clk;

  crc_stream_engine u8 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_last(din_last),
    .din_nbits(din_nbits), .clr(clr), .dout(d8), .dout_vld(v8),
`ifdef CRC_STREAM_CHECK_EN
    .crc_ok(ok8),
`endif
    .busy(b8));

  crc_stream_engine #(.CRC_W(16), .POLY(64'h1021), .INIT(64'hFFFF)) u16 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_last(din_last),
    .din_nbits(din_nbits), .clr(clr), .dout(d16), .dout_vld(v16),
`ifdef CRC_STREAM_CHECK_EN
    .crc_ok(ok16),
`endif
    .busy(b16));

  crc_stream_engine #(.CRC_W(32), .POLY(64'h04C11DB7), .INIT(64'hFFFFFFFF),
                      .XOR_OUT(64'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1)) u32 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_last(din_last),
    .din_nbits(din_nbits), .clr(clr), .dout(d32), .dout_vld(v32),
`ifdef CRC_STREAM_CHECK_EN
    .crc_ok(ok32),
`endif
    .busy(b32));

  crc_stream_engine #(.DATA_W(1)) ubit (
    .clk(clk), .rst(rst), .din(b_din), .din_vld(b_vld), .din_last(b_last),
    .din_nbits(b_nbits), .clr(b_clr), .dout(bd), .dout_vld(bv),
`ifdef CRC_STREAM_CHECK_EN
    .crc_ok(okb),
`endif
    .busy(bb));

  // Reference: CRC of a whole frame given as a list of message bits in
  // transmission order, using mask arithmetic on a 32-bit value.
  function automatic logic [31:0] model_crc(input bit bits[$], input int w,
                                            input logic [31:0] poly, input logic [31:0] init,
                                            input logic [31:0] xo, input bit refout);
    logic [31:0] mask, r, rr;
    bit top;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    r = init & mask;
    foreach (bits[k]) begin
      top = r[w-1];
      r = ((r << 1) ^ ((top ^ bits[k]) ? poly : 32'h0)) & mask;
    end
    if (refout) begin
      rr = '0;
      for (int i = 0; i < w; i++) rr[i] = r[w-1-i];
      r = rr;
    end
    return (r ^ xo) & mask;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One cycle on the shared byte bus; the model is updated right after the
  // edge that samples the word, so expectations line up with the DUT.
  task automatic applyStimulus(input logic [7:0] d, input bit v, input bit l,
                               input int nb, input bit c);
    int n;
    din = d; din_vld = v; din_last = l; din_nbits = 4'(nb); clr = c;
    @(posedge clk);
    if (c) begin
      msb_bits.delete(); lsb_bits.delete(); in_frame = 1'b0;
    end else if (v) begin
      n = (l && nb != 0) ? nb : 8;
      for (int b = 0; b < n; b++) begin
        msb_bits.push_back(d[7-b]);
        lsb_bits.push_back(d[b]);
      end
      if (l) begin
        hold[0] = model_crc(msb_bits, 8, 32'h07, 32'h0, 32'h0, 1'b0);
        hold[1] = model_crc(msb_bits, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0);
        hold[2] = model_crc(lsb_bits, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        for (int i = 0; i < 3; i++) sq[i].push_back(hold[i]);
        msb_bits.delete(); lsb_bits.delete(); in_frame = 1'b0;
      end else begin
        in_frame = 1'b1;
      end
    end
    #1;
    din_vld = 1'b0; din_last = 1'b0; clr = 1'b0; din_nbits = '0;
  endtask

  // One cycle on the bit-serial bus.
  task automatic applyBit(input bit d, input bit v, input bit l);
    b_din = d; b_vld = v; b_last = l;
    @(posedge clk);
    if (v) begin
      ser_bits.push_back(d);
      if (l) begin
        hold[3] = model_crc(ser_bits, 8, 32'h07, 32'h0, 32'h0, 1'b0);
        sq[3].push_back(hold[3]);
        ser_bits.delete(); b_in_frame = 1'b0;
      end else begin
        b_in_frame = 1'b1;
      end
    end
    #1;
    b_vld = 1'b0; b_last = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1; din_vld = 1'b0; b_vld = 1'b0;
    @(posedge clk);
    msb_bits.delete(); lsb_bits.delete(); ser_bits.delete();
    in_frame = 1'b0; b_in_frame = 1'b0;
    for (int i = 0; i < 4; i++) hold[i] = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic monitorOne(input int idx, input string name, input logic vld,
                            input logic [31:0] dv, input logic bz, input bit exp_bz);
    logic [31:0] e;
    if (vld) begin
      if (sq[idx].size() == 0) begin
        checkOutput({name, " strobe"}, {31'b0, vld}, 32'h0);
      end else begin
        e = sq[idx].pop_front();
        checkOutput({name, " dout"}, dv, e);
      end
    end else begin
      checkOutput({name, " hold"}, dv, hold[idx]);
    end
    checkOutput({name, " busy"}, {31'b0, bz}, {31'b0, exp_bz});
  endtask

  // Scoreboard monitor: every falling edge, pop on strobes, otherwise check
  // that dout holds the last result and busy tracks frame progress.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      monitorOne(0, "crc8", v8, {24'b0, d8}, b8, in_frame);
      monitorOne(1, "crc16", v16, {16'b0, d16}, b16, in_frame);
      monitorOne(2, "crc32", v32, d32, b32, in_frame);
      monitorOne(3, "serial", bv, {24'b0, bd}, bb, b_in_frame);
`ifdef CRC_STREAM_CHECK_EN
      checkOutput("crc8 crc_ok", {31'b0, ok8}, {31'b0, (v8 && hold[0] == 32'h0)});
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] msg[9];
    logic [7:0] r;
    int len;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 4; i++) hold[i] = '0;
    resetDut();
    mon_en = 1'b1;

    $display("[TB] reset state");
    checkOutput("reset dout8", {24'b0, d8}, 32'h0);
    checkOutput("reset vld8", {31'b0, v8}, 32'h0);
    checkOutput("reset busy8", {31'b0, b8}, 32'h0);
    checkOutput("reset dout32", d32, 32'h0);

    $display("[TB] single word 0xAB");
    applyStimulus(8'hAB, 1, 1, 0, 0);
    checkOutput("single 0xAB", {24'b0, d8}, 32'h58);
    checkOutput("single strobe", {31'b0, v8}, 32'h1);
    checkOutput("single busy", {31'b0, b8}, 32'h0);
    applyStimulus(8'h00, 0, 1, 3, 0);
    checkOutput("strobe one cycle", {31'b0, v8}, 32'h0);
    checkOutput("dout held", {24'b0, d8}, 32'h58);

    $display("[TB] partial last word");
    applyStimulus(8'hA0, 1, 1, 4, 0);
    checkOutput("partial 0xA0/4", {24'b0, d8}, 32'h36);

    $display("[TB] check strings");
    for (int i = 0; i < 9; i++) applyStimulus(msg[i], 1, i == 8, 0, 0);
    checkOutput("crc8 123456789", {24'b0, d8}, 32'hF4);
    checkOutput("crc16 123456789", {16'b0, d16}, 32'h29B1);
    checkOutput("crc32 123456789", d32, 32'hCBF43926);

    $display("[TB] clr mid-frame");
    applyStimulus(8'h11, 1, 0, 0, 0);
    checkOutput("busy in frame", {31'b0, b8}, 32'h1);
    applyStimulus(8'h22, 1, 1, 0, 1);
    checkOutput("no strobe on clr", {31'b0, v8}, 32'h0);
    checkOutput("busy after clr", {31'b0, b8}, 32'h0);
    applyStimulus(8'hAB, 1, 1, 0, 0);
    checkOutput("after clr 0xAB", {24'b0, d8}, 32'h58);

    $display("[TB] rst mid-frame");
    applyStimulus(8'h33, 1, 0, 0, 0);
    resetDut();
    checkOutput("rst dout8", {24'b0, d8}, 32'h0);
    checkOutput("rst busy8", {31'b0, b8}, 32'h0);
    checkOutput("rst dout16", {16'b0, d16}, 32'h0);
    applyStimulus(8'hAB, 1, 1, 0, 0);
    checkOutput("after rst 0xAB", {24'b0, d8}, 32'h58);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h01, 1, 1, 0, 0);
    checkOutput("b2b first", {24'b0, d8}, 32'h07);
    applyStimulus(8'hAB, 1, 1, 0, 0);
    checkOutput("b2b second", {24'b0, d8}, 32'h58);
    checkOutput("b2b strobe", {31'b0, v8}, 32'h1);

    $display("[TB] frames carrying their own CRC");
    applyStimulus(8'hAB, 1, 0, 0, 0);
    applyStimulus(8'h58, 1, 1, 0, 0);
    checkOutput("good residue", {24'b0, d8}, 32'h00);
`ifdef CRC_STREAM_CHECK_EN
    checkOutput("crc_ok good", {31'b0, ok8}, 32'h1);
`endif
    applyStimulus(8'hAB, 1, 0, 0, 0);
    applyStimulus(8'h59, 1, 1, 0, 0);
    checkOutput("bad residue", {24'b0, d8}, 32'h07);
`ifdef CRC_STREAM_CHECK_EN
    checkOutput("crc_ok bad", {31'b0, ok8}, 32'h0);
`endif

    $display("[TB] random frames");
    for (int f = 0; f < 80; f++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0)
          applyStimulus(8'($urandom), 0, 1'($urandom), $urandom_range(0, 8),
                        $urandom_range(0, 15) == 0);
        applyStimulus(8'($urandom), 1, k == len - 1, $urandom_range(0, 8),
                      $urandom_range(0, 24) == 0);
      end
    end

    $display("[TB] bit-serial engine");
    r = 8'hAB;
    for (int i = 7; i >= 0; i--) applyBit(r[i], 1, i == 0);
    checkOutput("serial 0xAB", {24'b0, bd}, 32'h58);
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) applyBit(1'($urandom), 0, 1'($urandom));
        applyBit(1'($urandom), 1, k == len - 1);
      end
    end

    repeat (3) applyStimulus(8'h00, 0, 0, 0, 0);
    checkOutput("crc8 drained", sq[0].size(), 32'h0);
    checkOutput("crc16 drained", sq[1].size(), 32'h0);
    checkOutput("crc32 drained", sq[2].size(), 32'h0);
    checkOutput("serial drained", sq[3].size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
